// File: rtl/bp_common_pkg.sv
// Shared types and helpers for the bp_common size serializer.
package bp_common_pkg;

   // Naturally-aligned payload sizes, encoded as log2(bytes).
   typedef enum logic [1:0] {
      e_size_1B = 2'd0,
      e_size_2B = 2'd1,
      e_size_4B = 2'd2,
      e_size_8B = 2'd3
   } bp_size_e;

   // Serializer control states.
   typedef enum logic {
      e_idle = 1'b0,
      e_send = 1'b1
   } bp_serializer_state_e;

   // Widest payload the replication helper can handle.
   localparam int unsigned max_data_width_gp = 512;
   localparam int unsigned max_data_idx_w_gp = $clog2(max_data_width_gp);

   // Number of out_width beats needed to carry a payload of 2**size bytes.
   function automatic int unsigned num_beats(input int unsigned size,
                                             input int unsigned out_width);
      int unsigned payload_bits;
      payload_bits = 32'd8 << size;
      return (payload_bits > out_width) ? (payload_bits / out_width) : 32'd1;
   endfunction

   // Repeats the low (8 << size) bits of data across the low width bits.
   function automatic logic [max_data_width_gp-1:0] replicate_to_width(
      input logic [max_data_width_gp-1:0] data,
      input int unsigned                  size,
      input int unsigned                  width);
      logic [max_data_width_gp-1:0] result;
      int unsigned                  mask;
      result = '0;
      mask   = (32'd8 << size) - 32'd1;
      for (int unsigned i = 0; i < max_data_width_gp; i++) begin
         if (i < width)
            result[max_data_idx_w_gp'(i)] = data[max_data_idx_w_gp'(i & mask)];
      end
      return result;
   endfunction

endpackage

// File: rtl/bp_common_beat_counter.sv
// Beat index counter: loads zero plus a last-index bound, increments per beat,
// and flags when the current index is the final one.
module bp_common_beat_counter
   import bp_common_pkg::*;
#(
   parameter int width_p = 2
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               load_i,
   input  logic [width_p-1:0] last_idx_i,
   input  logic               incr_i,
   output logic [width_p-1:0] count_o,
   output logic               last_o
);

   logic [width_p-1:0] count_r;
   logic [width_p-1:0] last_idx_r;

   // Count register: load restarts a payload, incr advances one beat.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         count_r    <= '0;
         last_idx_r <= '0;
      end else if (load_i) begin
         count_r    <= '0;
         last_idx_r <= last_idx_i;
      end else if (incr_i) begin
         count_r    <= count_r + width_p'(1);
      end
   end

   assign count_o = count_r;
   assign last_o  = (count_r == last_idx_r);

endmodule

// File: rtl/bp_common_size_serializer.sv
// Width gearbox: accepts one power-of-two sized payload and emits it as one
// or more out_data_width_p beats, replicating payloads narrower than a beat.
module bp_common_size_serializer
   import bp_common_pkg::*;
#(
   parameter int in_data_width_p  = 64,
   parameter int out_data_width_p = 16,
   // A 1-byte-wide input would give a zero-width size field; keep it at 1.
   localparam int size_width_lp = (in_data_width_p > 8)
                                  ? $clog2($clog2(in_data_width_p/8)+1) : 1,
   localparam int max_beats_lp  = in_data_width_p / out_data_width_p,
   localparam int beat_width_lp = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic [in_data_width_p-1:0]  data_i,
   input  logic [size_width_lp-1:0]    size_i,
   input  logic                        v_i,
   output logic                        ready_and_o,
   output logic [out_data_width_p-1:0] data_o,
   output logic [beat_width_lp-1:0]    beat_o,
   output logic                        last_o,
   output logic                        v_o,
   input  logic                        ready_and_i
);

   localparam int max_size_lp = $clog2(in_data_width_p/8);

   bp_serializer_state_e             state_r, state_n;
   logic [in_data_width_p-1:0]       data_r;
   logic [size_width_lp-1:0]         size_r;
   logic [size_width_lp-1:0]         size_clamped;
   logic [beat_width_lp-1:0]         last_idx_n;
   logic [beat_width_lp-1:0]         count;
   logic                             last;
   logic                             beat_done;
   logic                             accept;
   logic [max_data_width_gp-1:0]     data_ext;

   // Oversized requests are treated as a full-width payload.
   always_comb begin
      size_clamped = size_i;
      if (32'(size_i) > max_size_lp)
         size_clamped = size_width_lp'(max_size_lp);
      last_idx_n = beat_width_lp'(num_beats(32'(size_clamped), out_data_width_p) - 32'd1);
   end

   // Next-state and handshake decode; input is taken in IDLE or on the last beat.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_n     = state_r;
      ready_and_o = 1'b0;
      v_o         = 1'b0;
      unique case (state_r)
         e_idle: begin
            ready_and_o = 1'b1;
            if (v_i) state_n = e_send;
         end
         e_send: begin
            v_o = 1'b1;
            if (ready_and_i && last) begin
               ready_and_o = 1'b1;
               if (!v_i) state_n = e_idle;
            end
         end
         default: state_n = e_idle;
      endcase
   end

   assign beat_done = v_o & ready_and_i;
   assign accept    = v_i & ready_and_o;

   // State register.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_r <= e_idle;
      else            state_r <= state_n;
   end

   // Payload and size capture on acceptance.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         data_r <= '0;
         size_r <= '0;
      end else if (accept) begin
         data_r <= data_i;
         size_r <= size_clamped;
      end
   end

   bp_common_beat_counter #(
      .width_p(beat_width_lp)
   ) u_beat_counter (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .load_i     (accept),
      .last_idx_i (last_idx_n),
      .incr_i     (beat_done & ~last),
      .count_o    (count),
      .last_o     (last)
   );

   // Beat select: slice wide payloads, replicate sub-beat payloads across lanes.
   always_comb begin
      data_ext                      = '0;
      data_ext[in_data_width_p-1:0] = data_r;
      data_o = '0;
      beat_o = '0;
      last_o = 1'b0;
      if (state_r == e_send) begin
         beat_o = count;
         last_o = last;
         if ((32'd8 << size_r) >= out_data_width_p)
            data_o = data_r[32'(count) * out_data_width_p +: out_data_width_p];
         else
            data_o = out_data_width_p'(replicate_to_width(data_ext, 32'(size_r),
                                                          out_data_width_p));
      end
   end

   // Flag payload sizes wider than the input port.
   a_size_legal : assert property (@(posedge clk_i) disable iff (!reset_n_i)
      accept |-> (32'(size_i) <= max_size_lp))
      else $error("bp_common_size_serializer: illegal size_i %0d", size_i);

endmodule

// File: tb/tb_bp_common_size_serializer.sv
// Scoreboard bench for bp_common_size_serializer in three width configurations.
module tb_bp_common_size_serializer;

   typedef struct {
      logic [63:0] data;
      int          beat;
      bit          last;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] data_i;
   logic [2:0]   size_i;
   logic [2:0]   v_i;
   logic         ready_and_i;

   logic [15:0] d0;  logic [1:0] b0;  logic l0, v0, r0;
   logic [31:0] d1;  logic [1:0] b1;  logic l1, v1, r1;
   logic [63:0] d2;  logic [0:0] b2;  logic l2, v2, r2;
   logic [2:0]  rdy;

   int   tests = 0;
   int   fails = 0;
   exp_t q0[$], q1[$], q2[$];
   exp_t e0, e1, e2;

   always #5 clk = ~clk;
   assign rdy = {r2, r1, r0};

   bp_common_size_serializer #(.in_data_width_p(64), .out_data_width_p(16)) dut (
      .clk_i(clk), .reset_n_i(rst_n), .data_i(data_i[63:0]), .size_i(size_i[1:0]),
      .v_i(v_i[0]), .ready_and_o(r0), .data_o(d0), .beat_o(b0), .last_o(l0),
      .v_o(v0), .ready_and_i(ready_and_i));

   bp_common_size_serializer #(.in_data_width_p(128), .out_data_width_p(32)) dut_w (
      .clk_i(clk), .reset_n_i(rst_n), .data_i(data_i), .size_i(size_i),
      .v_i(v_i[1]), .ready_and_o(r1), .data_o(d1), .beat_o(b1), .last_o(l1),
      .v_o(v1), .ready_and_i(ready_and_i));

   bp_common_size_serializer #(.in_data_width_p(64), .out_data_width_p(64)) dut_p (
      .clk_i(clk), .reset_n_i(rst_n), .data_i(data_i[63:0]), .size_i(size_i[1:0]),
      .v_i(v_i[2]), .ready_and_o(r2), .data_o(d2), .beat_o(b2), .last_o(l2),
      .v_o(v2), .ready_and_i(ready_and_i));

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cmp_beat(input string nm, input exp_t e, input logic [63:0] d,
                           input int b, input bit l, input bit r);
      check({nm, ".data"},  d, e.data);
      check({nm, ".beat"},  64'(b), 64'(e.beat));
      check({nm, ".last"},  64'(l), 64'(e.last));
      check({nm, ".ready"}, 64'(r), 64'(e.last));
   endtask

   task automatic push(input int which, input logic [63:0] d, input int b, input bit l);
      exp_t e;
      e.data = d; e.beat = b; e.last = l;
      case (which)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Expected four 16-bit beats of a dword on the default configuration.
   task automatic push_dword16(input logic [63:0] d);
      for (int i = 0; i < 4; i++) push(0, (d >> (16*i)) & 64'hFFFF, i, i == 3);
   endtask

   task automatic send(input int which, input logic [127:0] d, input logic [2:0] s);
      bit ok = 1'b0;
      data_i = d; size_i = s; v_i = 3'b0; v_i[which] = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rdy[which]) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         tests++; fails++;
         $display("FAIL send_timeout: dut %0d never ready", which);
      end
      @(posedge clk); #1;
      v_i = 3'b0;
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         tests++; fails++;
         $display("FAIL drain_timeout: pending %0d %0d %0d", q0.size(), q1.size(), q2.size());
      end
      @(posedge clk); #1;
   endtask

   // Monitors: compare each accepted beat against the scoreboard head.
   always @(negedge clk) if (rst_n && v0 && ready_and_i) begin
      if (q0.size() == 0) begin tests++; fails++; $display("FAIL dut0.unexpected: got %h expected none", d0); end
      else begin e0 = q0.pop_front(); cmp_beat("dut0", e0, {48'b0, d0}, 32'(b0), l0, r0); end
   end
   always @(negedge clk) if (rst_n && v1 && ready_and_i) begin
      if (q1.size() == 0) begin tests++; fails++; $display("FAIL dutw.unexpected: got %h expected none", d1); end
      else begin e1 = q1.pop_front(); cmp_beat("dutw", e1, {32'b0, d1}, 32'(b1), l1, r1); end
   end
   always @(negedge clk) if (rst_n && v2 && ready_and_i) begin
      if (q2.size() == 0) begin tests++; fails++; $display("FAIL dutp.unexpected: got %h expected none", d2); end
      else begin e2 = q2.pop_front(); cmp_beat("dutp", e2, d2, 32'(b2), l2, r2); end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; data_i = '0; size_i = '0; v_i = '0; ready_and_i = 1'b1;
      #3;
      check("rst.v_o",   64'(v0), 64'd0);
      check("rst.ready", 64'(r0), 64'd1);
      check("rst.last",  64'(l0), 64'd0);
      check("rst.beat",  64'(b0), 64'd0);
      check("rst.data",  64'(d0), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Dword split into four beats.
      push_dword16(64'h1122334455667788);
      send(0, 128'h1122334455667788, 3'd3);
      drain();

      // Byte replicated (upper input bits are ignored), half passed as one beat.
      push(0, 64'hA5A5, 0, 1'b1);
      send(0, 128'h123456789ABCDEA5, 3'd0);
      drain();
      push(0, 64'hBEEF, 0, 1'b1);
      send(0, 128'hBEEF, 3'd1);
      drain();

      // Word under three cycles of backpressure on beat 0.
      push(0, 64'hBEEF, 0, 1'b0);
      push(0, 64'hDEAD, 1, 1'b1);
      ready_and_i = 1'b0;
      send(0, 128'hDEADBEEF, 3'd2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall.v_o",  64'(v0), 64'd1);
         check("stall.data", 64'(d0), 64'hBEEF);
         check("stall.beat", 64'(b0), 64'd0);
         check("stall.last", 64'(l0), 64'd0);
      end
      @(posedge clk); #1;
      ready_and_i = 1'b1;
      drain();

      // Back-to-back dwords with v_i held: eight beats, no bubble.
      push_dword16(64'h0123456789ABCDEF);
      push_dword16(64'hFEDCBA9876543210);
      data_i = 128'h0123456789ABCDEF; size_i = 3'd3; v_i = 3'b001;
      @(posedge clk); #1;
      data_i = 128'hFEDCBA9876543210;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("b2b.v_o_a",  64'(v0), 64'd1);
         check("b2b.accept", 64'(r0), 64'(k == 4));
      end
      @(posedge clk); #1;
      v_i = 3'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("b2b.v_o_b", 64'(v0), 64'd1);
      end
      drain();

      // Asynchronous reset in the middle of beat 1.
      push_dword16(64'hAAAABBBBCCCCDDDD);
      send(0, 128'hAAAABBBBCCCCDDDD, 3'd3);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("arst.v_o",   64'(v0), 64'd0);
      check("arst.ready", 64'(r0), 64'd1);
      check("arst.beat",  64'(b0), 64'd0);
      check("arst.last",  64'(l0), 64'd0);
      q0.delete();
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      push_dword16(64'h0F0E0D0C0B0A0908);
      send(0, 128'h0F0E0D0C0B0A0908, 3'd3);
      drain();

      // 128/32: a 16-byte payload yields four beats; a byte fills all lanes.
      push(1, 64'hCCDDEEFF, 0, 1'b0);
      push(1, 64'h8899AABB, 1, 1'b0);
      push(1, 64'h44556677, 2, 1'b0);
      push(1, 64'h00112233, 3, 1'b1);
      send(1, 128'h00112233445566778899AABBCCDDEEFF, 3'd4);
      drain();
      push(1, 64'h5A5A5A5A, 0, 1'b1);
      send(1, 128'h5A, 3'd0);
      drain();

      // 64/64: every size is one beat, narrower sizes replicated.
      push(2, 64'h3C3C3C3C3C3C3C3C, 0, 1'b1);
      send(2, 128'hFFFF_FF3C, 3'd0);
      drain();
      push(2, 64'hBEEFBEEFBEEFBEEF, 0, 1'b1);
      send(2, 128'h1234_BEEF, 3'd1);
      drain();
      push(2, 64'h1234567812345678, 0, 1'b1);
      send(2, 128'h12345678, 3'd2);
      drain();
      push(2, 64'h0011223344556677, 0, 1'b1);
      send(2, 128'h0011223344556677, 3'd3);
      drain();

      check("end.q0_empty", 64'(q0.size()), 64'd0);
      check("end.v_o_idle", 64'(v0), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bp_common_size_serializer.md
Name: bp_common_size_serializer

Overview:
- Parametrised data-width gearbox that accepts one naturally-sized payload (byte/half/word/dword, generalised to any power-of-two size up to in_data_width_p) and emits it as one or more out_data_width_p beats.
- Uses ready-and-valid handshakes on both sides.
- Sits between core-side producers (store data, uncached I/O) and narrower memory/network links.
- Generalises the fixed dword/word/half/byte widths to arbitrary in/out widths, and adds beat sequencing with sub-beat replication.

Parameters:
- in_data_width_p, 64, input payload width in bits; power of two, >= 8.
- out_data_width_p, 16, output beat width in bits; power of two, 8 <= out <= in.
- size_width_lp, $clog2($clog2(in_data_width_p/8)+1), derived; width of the log2-bytes size field.
- max_beats_lp, in_data_width_p/out_data_width_p, derived.
- beat_width_lp, max(1,$clog2(max_beats_lp)), derived.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- data_i  in  in_data_width_p  payload, LSB-aligned.
- size_i  in  size_width_lp  log2(bytes): 0=byte, 1=half, 2=word, 3=dword, ...
- v_i  in  1  input valid.
- ready_and_o  out  1  input ready.
- data_o  out  out_data_width_p  current beat.
- beat_o  out  beat_width_lp  index of current beat.
- last_o  out  1  current beat is final beat of payload.
- v_o  out  1  output valid.
- ready_and_i  in  1  downstream ready.

Behaviour:
- One clock domain; reset is asynchronous and active-low (reset_n_i). On assertion:
  - state=IDLE, beat counter=0, payload register=0.
  - v_o=0, ready_and_o=1, last_o=0, beat_o=0, data_o=0.
- FSM states: IDLE, SEND.
- IDLE:
  - ready_and_o=1, v_o=0.
  - On v_i&ready_and_o: latch data_i and size_i, counter=0, compute num_beats, go to SEND.
- num_beats = max(1, (8<<size)/out_data_width_p); 0-based last index is num_beats-1.
- size_i > $clog2(in_data_width_p/8) is illegal; the behaviour clamps it to the max size (full width). A simulation assertion fires on it.
- SEND: v_o=1, data_o = beat slice, beat_o=counter, last_o=(counter==num_beats-1).
  - Payload >= beat width: data_o = reg[counter*out +: out].
  - Payload < beat width: the low (8<<size) bits are replicated across all lanes of data_o. Example: out=16, byte 0xA5 -> 0xA5A5.
- Beat accepted (v_o&ready_and_i) and not last: counter increments, state stays SEND.
- Beat accepted and last:
  - ready_and_o=1 combinationally in that cycle.
  - If v_i is also high, the new payload is latched, counter=0, state stays SEND. This gives back-to-back payloads with no bubble.
  - Otherwise the block returns to IDLE.
- SEND with no last-beat handshake: ready_and_o=0. data_o, beat_o and last_o are held stable while v_o&~ready_and_i (no change under backpressure).
- Latency: first beat is valid the cycle after input acceptance (registered). Sustained throughput is one beat per cycle.
- Counter never wraps past num_beats-1. out==in gives a degenerate single-beat pass-through register.
- Reset mid-payload: remaining beats are discarded immediately (asynchronous). The first post-reset payload is unaffected.
- ready_and_o depends combinationally on ready_and_i only in the SEND-last cycle. There is no combinational path v_i -> v_o.

Decomposition:
- bp_common_pkg gets:
  - bp_size_e (e_size_1B, e_size_2B, e_size_4B, e_size_8B).
  - Function num_beats(size, out_width).
  - Function replicate_to_width(data, size, width).
- One sub-module, bp_common_beat_counter: load/increment/last-compare counter, parametrised by beat_width_lp.
- Slice/replicate mux stays inline.

Test Plan:
- Defaults, dword 0x1122334455667788, ready_and_i=1 -> beats 0x7788, 0x5566, 0x3344, 0x1122 on 4 consecutive cycles; beat_o 0..3; last_o only on beat 3; ready_and_o high on beat 3.
- Byte 0xA5 -> single beat 0xA5A5, last_o=1, beat_o=0; half 0xBEEF -> single beat 0xBEEF.
- Word 0xDEADBEEF with ready_and_i low for 3 cycles on beat 0 -> data_o holds 0xBEEF for those cycles, then 0xDEAD, last_o=1.
- Two dwords presented back-to-back with v_i held -> 8 consecutive beats with no idle cycle; second payload accepted exactly in the cycle of the first payload's last-beat handshake.
- reset_n_i pulsed low mid-beat 1 (between clock edges) -> v_o falls immediately with no clock; ready_and_o=1; next dword emits beat 0 first.
- Param sweep in=128/out=32 and in=out=64: a 16B payload yields 4 beats; in the 64/64 configuration every size yields one beat with correct replication (word 0x12345678 -> 0x1234567812345678).
